// File: rtl/pcie_bas_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_bas_wr_arbiter
//  Purpose  : Burst-granular round-robin arbiter sharing the PCIe BAS
//             Avalon-MM write port among NUM_REQ write masters.
//  Revision : 1.0
// ============================================================================
module pcie_bas_wr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_reset,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*64-1:0]  req_address,
    input  logic [NUM_REQ*64-1:0]  req_byteenable,
    input  logic [NUM_REQ*512-1:0] req_writedata,
    input  logic [NUM_REQ*4-1:0]   req_burstcount,
    output logic [NUM_REQ-1:0]     req_waitrequest,
    input  logic                   pcie_bas_waitrequest,
    output logic [63:0]            pcie_bas_address,
    output logic [63:0]            pcie_bas_byteenable,
    output logic                   pcie_bas_write,
    output logic [511:0]           pcie_bas_writedata,
    output logic [3:0]             pcie_bas_burstcount,
    output logic                   pcie_bas_read,
    output logic [NUM_REQ*32-1:0]  burst_cnt,
    output logic [31:0]            stall_cnt
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr_ptr;
    logic [3:0]      r_beats_left;
    logic [31:0]     r_burst_cnt [NUM_REQ];
    logic [31:0]     r_stall_cnt;

    logic [63:0]     w_addr [NUM_REQ];
    logic [63:0]     w_be   [NUM_REQ];
    logic [511:0]    w_data [NUM_REQ];
    logic [3:0]      w_bcnt [NUM_REQ];

    logic [GW-1:0]   w_sel;
    logic [GW-1:0]   w_idle_pick;
    logic [GW-1:0]   w_other_pick;
    logic [GW-1:0]   w_grant_inc;
    logic            w_any_req;
    logic            w_other_req;
    logic            w_accept;
    logic            w_first;
    logic            w_last;
    logic [3:0]      w_bc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi] = req_address[gi*64 +: 64];
            assign w_be[gi]   = req_byteenable[gi*64 +: 64];
            assign w_data[gi] = req_writedata[gi*512 +: 512];
            assign w_bcnt[gi] = req_burstcount[gi*4 +: 4];
            assign req_waitrequest[gi] = (r_state == ST_BURST && r_grant == GW'(gi))
                                         ? pcie_bas_waitrequest : 1'b1;
            assign burst_cnt[gi*32 +: 32] = r_burst_cnt[gi];
        end
    endgenerate

    // Idle presents requester 0 so the bus never floats between bursts.
    assign w_sel               = (r_state == ST_BURST) ? r_grant : '0;
    assign pcie_bas_address    = w_addr[w_sel];
    assign pcie_bas_byteenable = w_be[w_sel];
    assign pcie_bas_writedata  = w_data[w_sel];
    assign pcie_bas_burstcount = w_bcnt[w_sel];
    assign pcie_bas_write      = (r_state == ST_BURST) && req_write[r_grant];
    assign pcie_bas_read       = 1'b0;
    assign stall_cnt           = r_stall_cnt;

    assign w_bc        = w_bcnt[r_grant];
    assign w_accept    = (r_state == ST_BURST) && req_write[r_grant] && !pcie_bas_waitrequest;
    assign w_first     = (r_beats_left == 4'd0);
    assign w_last      = w_accept && ((w_first && w_bc == 4'd1) || (r_beats_left == 4'd1));
    assign w_grant_inc = GW'((int'(r_grant) + 1) % NUM_REQ);

    // Scan downward so the lowest offset from the starting point wins.
    always_comb begin
        logic [GW-1:0] idx;
        idx          = '0;
        w_any_req    = |req_write;
        w_idle_pick  = r_rr_ptr;
        w_other_req  = 1'b0;
        w_other_pick = r_grant;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_write[idx]) w_idle_pick = idx;
        end
        for (int k = NUM_REQ - 1; k >= 1; k--) begin
            idx = GW'((int'(r_grant) + k) % NUM_REQ);
            if (req_write[idx]) begin
                w_other_req  = 1'b1;
                w_other_pick = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_beats_left <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_idle_pick;
                        r_state      <= ST_BURST;
                        r_beats_left <= '0;
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_rr_ptr     <= w_grant_inc;
                            r_beats_left <= '0;
                            // Back-to-back handover avoids an idle bubble.
                            if (w_other_req) r_grant <= w_other_pick;
                            else             r_state <= ST_IDLE;
                        end else if (w_first) begin
                            r_beats_left <= w_bc - 4'd1;
                        end else begin
                            r_beats_left <= r_beats_left - 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || sw_reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_burst_cnt[i] <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_last) r_burst_cnt[r_grant] <= r_burst_cnt[r_grant] + 32'd1;
            if (pcie_bas_write && pcie_bas_waitrequest) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

`ifndef SYNTHESIS
    logic          r_chk_hold;
    logic [GW-1:0] r_chk_grant;
    always_ff @(posedge clk) begin
        r_chk_hold  <= rst_n && (r_state == ST_BURST) && (r_beats_left != 4'd0) && !w_last;
        r_chk_grant <= r_grant;
        if (rst_n && w_accept && w_first)
            assert (w_bc != 4'd0 && int'(w_bc) <= MAX_BURST)
                else $fatal(1, "illegal burstcount %0d on first beat", w_bc);
        if (rst_n && r_chk_hold)
            assert (r_grant == r_chk_grant)
                else $fatal(1, "grant changed mid-burst");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_bas_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcie_bas_wr_arbiter
//  Purpose  : Table-driven bench for pcie_bas_wr_arbiter with directed
//             reset / sw_reset sequences.
//  Revision : 1.0
// ============================================================================
module tb_pcie_bas_wr_arbiter;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sw_reset;
    logic [1:0]     req_write;
    logic [127:0]   req_address;
    logic [127:0]   req_byteenable;
    logic [1023:0]  req_writedata;
    logic [7:0]     req_burstcount;
    logic [1:0]     req_waitrequest;
    logic           pcie_bas_waitrequest;
    logic [63:0]    pcie_bas_address;
    logic [63:0]    pcie_bas_byteenable;
    logic           pcie_bas_write;
    logic [511:0]   pcie_bas_writedata;
    logic [3:0]     pcie_bas_burstcount;
    logic           pcie_bas_read;
    logic [63:0]    burst_cnt;
    logic [31:0]    stall_cnt;
    logic [3:0]     bc0;
    logic [3:0]     bc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign req_burstcount = {bc1, bc0};

    pcie_bas_wr_arbiter #(.NUM_REQ(2), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n), .sw_reset(sw_reset),
        .req_write(req_write), .req_address(req_address),
        .req_byteenable(req_byteenable), .req_writedata(req_writedata),
        .req_burstcount(req_burstcount), .req_waitrequest(req_waitrequest),
        .pcie_bas_waitrequest(pcie_bas_waitrequest),
        .pcie_bas_address(pcie_bas_address), .pcie_bas_byteenable(pcie_bas_byteenable),
        .pcie_bas_write(pcie_bas_write), .pcie_bas_writedata(pcie_bas_writedata),
        .pcie_bas_burstcount(pcie_bas_burstcount), .pcie_bas_read(pcie_bas_read),
        .burst_cnt(burst_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [1:0] wr;
        logic       wt;
        logic [3:0] b0;
        logic [3:0] b1;
        logic       exp_wr;
        logic [7:0] exp_tag;
        logic [1:0] exp_wreq;
    } vec_t;

    localparam int NV = 40;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic put(input int lo, input int hi, input logic [1:0] wr, input logic wt,
                       input logic [3:0] b0, input logic [3:0] b1, input logic ewr,
                       input logic [7:0] etag, input logic [1:0] ewreq);
        for (int i = lo; i <= hi; i++) begin
            tbl[i].wr = wr; tbl[i].wt = wt; tbl[i].b0 = b0; tbl[i].b1 = b1;
            tbl[i].exp_wr = ewr; tbl[i].exp_tag = etag; tbl[i].exp_wreq = ewreq;
        end
    endtask

    // Expected counter = number of listed event rows strictly before row i.
    function automatic int count_before(input int i, input int rows[$]);
        int n = 0;
        foreach (rows[k]) if (rows[k] < i) n++;
        return n;
    endfunction

    task automatic step_chk_data(input string nm, input logic [7:0] tag);
        chk({nm, "_tag"}, {56'd0, pcie_bas_writedata[7:0]}, {56'd0, tag});
        chk({nm, "_addr"}, pcie_bas_address, (tag == 8'h11) ? 64'h1000 : 64'h2000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0_end[$];
        int b1_end[$];
        int st_rows[$];
        b0_end  = '{8, 12, 14, 24, 38};
        b1_end  = '{11, 13, 26};
        st_rows = '{30, 31, 32, 34, 35, 36};

        rst_n = 1'b0; sw_reset = 1'b0; req_write = 2'b00; pcie_bas_waitrequest = 1'b0;
        bc0 = 4'd1; bc1 = 4'd1;
        req_address    = {64'h2000, 64'h1000};
        req_byteenable = {64'h0000_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        req_writedata  = {512'h22, 512'h11};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_write", {63'd0, pcie_bas_write}, 64'd0);
        chk("rst_wreq", {62'd0, req_waitrequest}, 64'd3);
        chk("rst_burst_cnt", burst_cnt, 64'd0);
        chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        chk("rst_read", {63'd0, pcie_bas_read}, 64'd0);

        // single burst of 8
        put(0, 0,   2'b01, 1'b0, 4'd8, 4'd1, 1'b0, 8'h11, 2'b11);
        put(1, 8,   2'b01, 1'b0, 4'd8, 4'd1, 1'b1, 8'h11, 2'b10);
        put(9, 9,   2'b00, 1'b0, 4'd8, 4'd1, 1'b0, 8'h11, 2'b11);
        // alternating single-beat bursts
        put(10, 10, 2'b11, 1'b0, 4'd1, 4'd1, 1'b0, 8'h11, 2'b11);
        put(11, 11, 2'b11, 1'b0, 4'd1, 4'd1, 1'b1, 8'h22, 2'b01);
        put(12, 12, 2'b11, 1'b0, 4'd1, 4'd1, 1'b1, 8'h11, 2'b10);
        put(13, 13, 2'b11, 1'b0, 4'd1, 4'd1, 1'b1, 8'h22, 2'b01);
        put(14, 14, 2'b01, 1'b0, 4'd1, 4'd1, 1'b1, 8'h11, 2'b10);
        put(15, 15, 2'b00, 1'b0, 4'd1, 4'd1, 1'b0, 8'h11, 2'b11);
        // req1 arrives mid req0 burst
        put(16, 16, 2'b01, 1'b0, 4'd8, 4'd2, 1'b0, 8'h11, 2'b11);
        put(17, 19, 2'b01, 1'b0, 4'd8, 4'd2, 1'b1, 8'h11, 2'b10);
        put(20, 24, 2'b11, 1'b0, 4'd8, 4'd2, 1'b1, 8'h11, 2'b10);
        put(25, 26, 2'b10, 1'b0, 4'd8, 4'd2, 1'b1, 8'h22, 2'b01);
        put(27, 27, 2'b00, 1'b0, 4'd8, 4'd2, 1'b0, 8'h11, 2'b11);
        // burst of 4 with backpressure on beats 2 and 3
        put(28, 28, 2'b01, 1'b0, 4'd4, 4'd1, 1'b0, 8'h11, 2'b11);
        put(29, 29, 2'b01, 1'b0, 4'd4, 4'd1, 1'b1, 8'h11, 2'b10);
        put(30, 32, 2'b01, 1'b1, 4'd4, 4'd1, 1'b1, 8'h11, 2'b11);
        put(33, 33, 2'b01, 1'b0, 4'd4, 4'd1, 1'b1, 8'h11, 2'b10);
        put(34, 36, 2'b01, 1'b1, 4'd4, 4'd1, 1'b1, 8'h11, 2'b11);
        put(37, 38, 2'b01, 1'b0, 4'd4, 4'd1, 1'b1, 8'h11, 2'b10);
        put(39, 39, 2'b00, 1'b0, 4'd4, 4'd1, 1'b0, 8'h11, 2'b11);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            req_write = tbl[i].wr; pcie_bas_waitrequest = tbl[i].wt;
            bc0 = tbl[i].b0; bc1 = tbl[i].b1;
            #1;
            chk($sformatf("v%0d_write", i), {63'd0, pcie_bas_write}, {63'd0, tbl[i].exp_wr});
            chk($sformatf("v%0d_wreq", i), {62'd0, req_waitrequest}, {62'd0, tbl[i].exp_wreq});
            step_chk_data($sformatf("v%0d", i), tbl[i].exp_tag);
            chk($sformatf("v%0d_bcount", i), {60'd0, pcie_bas_burstcount},
                {60'd0, (tbl[i].exp_tag == 8'h11) ? tbl[i].b0 : tbl[i].b1});
            chk($sformatf("v%0d_burst0", i), {32'd0, burst_cnt[31:0]},
                64'(count_before(i, b0_end)));
            chk($sformatf("v%0d_burst1", i), {32'd0, burst_cnt[63:32]},
                64'(count_before(i, b1_end)));
            chk($sformatf("v%0d_stall", i), {32'd0, stall_cnt}, 64'(count_before(i, st_rows)));
        end

        // sw_reset mid-burst, coinciding with a stall cycle
        @(negedge clk); req_write = 2'b10; bc1 = 4'd3; pcie_bas_waitrequest = 1'b0; #1;
        chk("sw_arb_write", {63'd0, pcie_bas_write}, 64'd0);
        @(negedge clk); #1;
        chk("sw_beat1_write", {63'd0, pcie_bas_write}, 64'd1);
        step_chk_data("sw_beat1", 8'h22);
        @(negedge clk); pcie_bas_waitrequest = 1'b1; sw_reset = 1'b1; #1;
        chk("sw_stall_wreq", {62'd0, req_waitrequest}, 64'd3);
        chk("sw_stall_before", {32'd0, stall_cnt}, 64'd6);
        @(negedge clk); pcie_bas_waitrequest = 1'b0; sw_reset = 1'b0; #1;
        chk("sw_cleared_burst", burst_cnt, 64'd0);
        chk("sw_cleared_stall", {32'd0, stall_cnt}, 64'd0);
        @(negedge clk); #1;
        chk("sw_beat3_write", {63'd0, pcie_bas_write}, 64'd1);
        @(negedge clk); req_write = 2'b00; #1;
        chk("sw_done_write", {63'd0, pcie_bas_write}, 64'd0);
        chk("sw_done_burst", burst_cnt, {32'd1, 32'd0});
        chk("sw_done_stall", {32'd0, stall_cnt}, 64'd0);

        // rst_n asserted during beat 3 of 8
        @(negedge clk); req_write = 2'b01; bc0 = 4'd8; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst3_beat3_write", {63'd0, pcie_bas_write}, 64'd1);
        @(negedge clk); rst_n = 1'b1; req_write = 2'b11; bc0 = 4'd2; bc1 = 4'd1; #1;
        chk("rst3_after_write", {63'd0, pcie_bas_write}, 64'd0);
        chk("rst3_after_wreq", {62'd0, req_waitrequest}, 64'd3);
        chk("rst3_after_burst", burst_cnt, 64'd0);
        chk("rst3_after_stall", {32'd0, stall_cnt}, 64'd0);
        @(negedge clk); #1;
        chk("rst3_new_b1_write", {63'd0, pcie_bas_write}, 64'd1);
        step_chk_data("rst3_new_b1", 8'h11);
        @(negedge clk); #1;
        step_chk_data("rst3_new_b2", 8'h11);
        @(negedge clk); req_write = 2'b10; #1;
        chk("rst3_req1_write", {63'd0, pcie_bas_write}, 64'd1);
        step_chk_data("rst3_req1", 8'h22);
        @(negedge clk); req_write = 2'b00; #1;
        chk("rst3_end_write", {63'd0, pcie_bas_write}, 64'd0);
        chk("rst3_end_burst", burst_cnt, {32'd1, 32'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
